rca_seq_ctrl: RTL and testbench

Multi-cycle sequencer that adds two wide operands (SIZE*WORDS bits) using one shared SIZE-bit RCA instance. It processes one SIZE-bit chunk per cycle, LSB chunk first, and carries between chunks in a register. It sits between the ALU operand/issue logic and the adder datapath, with valid/ready handshakes on both sides. It lets the 8-bit ALU perform 16/32-bit adds without a wider adder.

---
 rtl/rca_seq_pkg.sv | 28 ++
 rtl/rca_seq_ctrl_rca.sv | 23 ++
 rtl/rca_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the chunked RCA add sequencer.
package rca_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

   // Chunk index needs at least one bit even when there is a single chunk.
   function automatic int idx_width(input int words);
      return (clog2(words) < 1) ? 1 : clog2(words);
   endfunction

endpackage

// File: rtl/rca_seq_ctrl_rca.sv
// Plain SIZE-bit ripple-carry adder; carry-in is tied low, full sum is SIZE+1 bits.
module rca #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE:0]   sum
);

   logic [SIZE:0] carry_s;

   // Bit-serial full-adder chain.
   always_comb begin
      carry_s = {(SIZE+1){1'b0}};
      sum     = {(SIZE+1){1'b0}};
      for (int i = 0; i < SIZE; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
      sum[SIZE] = carry_s[SIZE];
   end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle wide adder: one SIZE-bit chunk per cycle through a shared RCA,
// LSB chunk first, with the inter-chunk carry held in a register.
module rca_seq_ctrl
   import rca_seq_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SIZE*WORDS-1:0] a,
   input  logic [SIZE*WORDS-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SIZE*WORDS:0]   result,
   output logic                  overflow,
   output logic                  busy
);

   localparam int W     = SIZE * WORDS;
   localparam int IDX_W = idx_width(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W:0]       result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             out_valid_q, out_valid_d;

   logic [SIZE-1:0]  a_chunk;
   logic [SIZE-1:0]  b_chunk;
   logic [SIZE:0]    rca_sum;
   logic [SIZE-1:0]  chunk_sum;
   logic             inc_co;
   logic             chunk_carry;

   assign a_chunk = a_q[idx_q*SIZE +: SIZE];
   assign b_chunk = b_q[idx_q*SIZE +: SIZE];

   rca #(.SIZE(SIZE)) u_rca (
      .a   (a_chunk),
      .b   (b_chunk),
      .sum (rca_sum)
   );

   // Fold the stored carry in after the RCA; the two carry sources are exclusive,
   // since a carry out of the RCA leaves at most 2^SIZE-2 in the low bits.
   always_comb begin
      {inc_co, chunk_sum} = {1'b0, rca_sum[SIZE-1:0]} + {{SIZE{1'b0}}, carry_q};
      chunk_carry         = rca_sum[SIZE] | inc_co;
   end

   // Next-state and datapath update for the sequencer FSM.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               carry_d    = 1'b0;
               idx_d      = {IDX_W{1'b0}};
               result_d   = {(W+1){1'b0}};
               overflow_d = 1'b0;
               state_d    = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            result_d[idx_q*SIZE +: SIZE] = chunk_sum;
            carry_d                      = chunk_carry;
            if (idx_q == LAST_IDX) begin
               result_d[W] = chunk_carry;
               overflow_d  = chunk_carry;
               out_valid_d = 1'b1;
               idx_d       = {IDX_W{1'b0}};
               state_d     = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= {IDX_W{1'b0}};
         carry_q     <= 1'b0;
         a_q         <= {W{1'b0}};
         b_q         <= {W{1'b0}};
         result_q    <= {(W+1){1'b0}};
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (SIZE=8, WORDS=4) with hand-computed sums.
module tb_rca_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] result;
   logic        overflow;
   logic        busy;

   int n_checks;
   int n_errors;

   rca_seq_ctrl #(.SIZE(8), .WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with out_ready high, verify latency, sum and return to idle.
   task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [32:0] exp_res);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = op_a;
      b         = op_b;
      check_eq({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      a        = 32'hDEAD_BEEF;
      b        = 32'hCAFE_F00D;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         check_eq({tag, ".busy_run"}, 64'(busy), 64'd1);
         tick();
         lat++;
      end
      check_eq({tag, ".latency"}, 64'(lat), 64'd4);
      check_eq({tag, ".result"}, 64'(result), 64'(exp_res));
      check_eq({tag, ".overflow"}, 64'(overflow), 64'(exp_res[32]));
      check_eq({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
      tick();
      check_eq({tag, ".out_valid_clr"}, 64'(out_valid), 64'd0);
      check_eq({tag, ".busy_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int lat;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'h0;
      b         = 32'h0;
      tick();
      tick();
      check_eq("rst.in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rst.out_valid", 64'(out_valid), 64'd0);
      check_eq("rst.busy", 64'(busy), 64'd0);
      check_eq("rst.result", 64'(result), 64'd0);
      check_eq("rst.overflow", 64'(overflow), 64'd0);
      check_eq("rst.in_ready_after", 64'(in_ready), 64'd1);

      run_op("t1", 32'h0000_0001, 32'h0000_0002, 33'h0_0000_0003);
      run_op("t2", 32'h0000_00FF, 32'h0000_0001, 33'h0_0000_0100);
      run_op("t3", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
      run_op("t4a", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
      run_op("t4b", 32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000);

      // Back-pressure in DONE while a second request waits.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 32'h1234_5678;
      b         = 32'h1111_1111;
      tick();
      a   = 32'h0000_0001;
      b   = 32'h0000_0001;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         check_eq("t5.in_ready_run", 64'(in_ready), 64'd0);
         tick();
         lat++;
      end
      check_eq("t5.latency", 64'(lat), 64'd4);
      for (int i = 0; i < 3; i++) begin
         check_eq("t5.hold_result", 64'(result), 64'h0_2345_6789);
         check_eq("t5.hold_ovf", 64'(overflow), 64'd0);
         check_eq("t5.hold_valid", 64'(out_valid), 64'd1);
         check_eq("t5.hold_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check_eq("t5.idle_valid", 64'(out_valid), 64'd0);
      check_eq("t5.idle_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check_eq("t5.second_lat", 64'(lat), 64'd4);
      check_eq("t5.second_result", 64'(result), 64'h0_0000_0002);
      tick();

      // Reset in the middle of RUN at chunk index 2.
      in_valid = 1'b1;
      a        = 32'hFFFF_FFFF;
      b        = 32'h0000_0001;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_eq("t6.in_ready_rst", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("t6.out_valid", 64'(out_valid), 64'd0);
      check_eq("t6.busy", 64'(busy), 64'd0);
      check_eq("t6.result", 64'(result), 64'd0);
      check_eq("t6.overflow", 64'(overflow), 64'd0);
      check_eq("t6.in_ready", 64'(in_ready), 64'd1);
      tick();
      check_eq("t6.no_pulse", 64'(out_valid), 64'd0);
      run_op("t6b", 32'h0000_0005, 32'h0000_0003, 33'h0_0000_0008);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
